fu_issue_scoreboard: RTL and testbench

FU_ISSUE_SCOREBOARD -- requirements
Module: fu_issue_scoreboard

---
 rtl/fu_issue_scoreboard.sv | 162 ++++++++++++++++
 tb/tb_fu_issue_scoreboard.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_scoreboard.sv
// Issue scoreboard for multicycle functional units: RAW/WAW/structural stall and write-back arbitration.
// Define FU_ARB_RR_EN for round-robin write-back arbitration; default is fixed priority (lowest index wins).
module fu_issue_scoreboard #(
    parameter int N_FU   = 7,
    parameter int REG_AW = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      issue_valid,
    input  logic [N_FU-1:0]           issue_fu,
    input  logic                      issue_wr,
    input  logic                      issue_rd_fp,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [REG_AW-1:0]         src_rs1,
    input  logic [REG_AW-1:0]         src_rs2,
    input  logic [REG_AW-1:0]         src_rs3,
    input  logic [2:0]                src_use,
    input  logic [2:0]                src_fp,
    input  logic [N_FU-1:0]           fu_busy,
    input  logic [N_FU-1:0]           fu_done,
    output logic                      issue_stall,
    output logic [N_FU-1:0]           wb_grant,
    output logic [N_FU-1:0]           fu_hold,
    output logic [REG_AW-1:0]         wb_rd,
    output logic                      wb_rd_fp,
    output logic                      wb_wr,
    output logic [$clog2(N_FU+1)-1:0] outstanding
);
    localparam int NREG = 1 << REG_AW;
    localparam int IW   = $clog2(N_FU);
    localparam int OW   = $clog2(N_FU + 1);

    logic [NREG-1:0]   busy_int_q, busy_int_d;
    logic [NREG-1:0]   busy_fp_q, busy_fp_d;
    logic [N_FU-1:0]   pending_q, pending_d;
    logic [REG_AW-1:0] slot_rd_q [N_FU];
    logic [N_FU-1:0]   slot_fp_q, slot_wr_q;
    logic [OW-1:0]     outstanding_q, outstanding_d;

    logic [N_FU-1:0]   req;
    logic              grant_any;
    logic [IW-1:0]     gidx;
    logic              raw_haz, waw_haz, struct_haz, accept;
    logic [REG_AW-1:0] src_idx [3];

    assign src_idx[0] = src_rs1;
    assign src_idx[1] = src_rs2;
    assign src_idx[2] = src_rs3;

    // Int x0 is hardwired, so it never participates in hazards.
    always_comb begin
        raw_haz = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (src_use[s]) begin
                if (src_fp[s]) raw_haz = raw_haz | busy_fp_q[src_idx[s]];
                else           raw_haz = raw_haz | (busy_int_q[src_idx[s]] & (src_idx[s] != '0));
            end
        end
    end

    assign waw_haz    = issue_wr & (issue_rd_fp ? busy_fp_q[issue_rd]
                                                : (busy_int_q[issue_rd] & (issue_rd != '0)));
    assign struct_haz = (|(issue_fu & fu_busy)) | (|(issue_fu & pending_q & ~wb_grant));
    assign issue_stall = issue_valid & (raw_haz | waw_haz | struct_haz);
    assign accept      = issue_valid & ~issue_stall;

    assign req = fu_done & pending_q;

`ifdef FU_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        gidx      = '0;
        for (int i = 0; i < N_FU; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_FU) idx = idx - N_FU;
            if (!grant_any && req[idx]) begin
                grant_any = 1'b1;
                gidx      = IW'(idx);
            end
        end
        ptr_d = ptr_q;
        if (grant_any) ptr_d = (gidx == IW'(N_FU - 1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`else
    always_comb begin
        grant_any = 1'b0;
        gidx      = '0;
        for (int i = N_FU - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_any = 1'b1;
                gidx      = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        wb_grant = '0;
        if (grant_any) wb_grant[gidx] = 1'b1;
    end

    assign fu_hold     = req & ~wb_grant;
    assign wb_rd       = grant_any ? slot_rd_q[gidx] : '0;
    assign wb_rd_fp    = grant_any & slot_fp_q[gidx];
    assign wb_wr       = grant_any & slot_wr_q[gidx];
    assign outstanding = outstanding_q;

    // Grant clears first so a same-cycle set wins.
    always_comb begin
        busy_int_d = busy_int_q;
        busy_fp_d  = busy_fp_q;
        pending_d  = pending_q;
        if (grant_any) begin
            pending_d[gidx] = 1'b0;
            if (slot_wr_q[gidx]) begin
                if (slot_fp_q[gidx]) busy_fp_d[slot_rd_q[gidx]]  = 1'b0;
                else                 busy_int_d[slot_rd_q[gidx]] = 1'b0;
            end
        end
        if (accept) begin
            pending_d = pending_d | issue_fu;
            if (issue_wr) begin
                if (issue_rd_fp)             busy_fp_d[issue_rd]  = 1'b1;
                else if (issue_rd != '0)     busy_int_d[issue_rd] = 1'b1;
            end
        end
        outstanding_d = outstanding_q + OW'(accept) - OW'(grant_any);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_int_q    <= '0;
            busy_fp_q     <= '0;
            pending_q     <= '0;
            slot_fp_q     <= '0;
            slot_wr_q     <= '0;
            outstanding_q <= '0;
            for (int k = 0; k < N_FU; k++) slot_rd_q[k] <= '0;
        end else begin
            busy_int_q    <= busy_int_d;
            busy_fp_q     <= busy_fp_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            for (int k = 0; k < N_FU; k++) begin
                if (accept && issue_fu[k]) begin
                    slot_rd_q[k] <= issue_rd;
                    slot_fp_q[k] <= issue_rd_fp;
                    slot_wr_q[k] <= issue_wr;
                end
            end
        end
    end
endmodule

// File: tb/tb_fu_issue_scoreboard.sv
// Bench for fu_issue_scoreboard: expected write-backs are queued by the stimulus and popped by a grant monitor.
module tb_fu_issue_scoreboard;
    localparam int N_FU   = 7;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              issue_valid;
    logic [N_FU-1:0]   issue_fu;
    logic              issue_wr, issue_rd_fp;
    logic [REG_AW-1:0] issue_rd, src_rs1, src_rs2, src_rs3;
    logic [2:0]        src_use, src_fp;
    logic [N_FU-1:0]   fu_busy, fu_done;
    logic              issue_stall;
    logic [N_FU-1:0]   wb_grant, fu_hold;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_rd_fp, wb_wr;
    logic [2:0]        outstanding;

    typedef struct packed {
        logic [N_FU-1:0]   grant;
        logic [REG_AW-1:0] rd;
        logic              fp;
        logic              wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fu_issue_scoreboard #(.N_FU(N_FU), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_wr(issue_wr),
        .issue_rd_fp(issue_rd_fp), .issue_rd(issue_rd),
        .src_rs1(src_rs1), .src_rs2(src_rs2), .src_rs3(src_rs3),
        .src_use(src_use), .src_fp(src_fp),
        .fu_busy(fu_busy), .fu_done(fu_done),
        .issue_stall(issue_stall), .wb_grant(wb_grant), .fu_hold(fu_hold),
        .wb_rd(wb_rd), .wb_rd_fp(wb_rd_fp), .wb_wr(wb_wr), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Grant monitor: every grant must match the next queued expectation.
    always @(negedge clk) begin
        if (wb_grant != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: got grant=%b rd=%0d", wb_grant, wb_rd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wb_grant != e.grant || wb_rd != e.rd || wb_rd_fp != e.fp || wb_wr != e.wr) begin
                    errors++;
                    $display("FAIL wb: got grant=%b rd=%0d fp=%0d wr=%0d, want grant=%b rd=%0d fp=%0d wr=%0d",
                             wb_grant, wb_rd, wb_rd_fp, wb_wr, e.grant, e.rd, e.fp, e.wr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N_FU-1:0] g, input logic [REG_AW-1:0] rd,
                        input logic fp, input logic wr);
        exp_t e;
        e.grant = g; e.rd = rd; e.fp = fp; e.wr = wr;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_fu = '0; issue_wr = 1'b0; issue_rd_fp = 1'b0;
        issue_rd = '0; src_rs1 = '0; src_rs2 = '0; src_rs3 = '0;
        src_use = '0; src_fp = '0; fu_busy = '0;
    endtask

    task automatic issue(input logic [N_FU-1:0] fu, input logic wr, input logic rfp,
                         input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] r1,
                         input logic [REG_AW-1:0] r2, input logic [2:0] use_b,
                         input logic [2:0] fp_b);
        issue_valid = 1'b1; issue_fu = fu; issue_wr = wr; issue_rd_fp = rfp;
        issue_rd = rd; src_rs1 = r1; src_rs2 = r2; src_rs3 = '0;
        src_use = use_b; src_fp = fp_b;
    endtask

    task automatic do_reset();
        idle();
        fu_done = '0;
        reset_n = 1'b0;
        #2;
        chk("reset_outstanding", 32'(outstanding), 0);
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        idle();
        fu_done = '0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk("reset_stall", 32'(issue_stall), 0);
        chk("reset_grant", 32'(wb_grant), 0);
        chk("idle_wb_rd", 32'(wb_rd), 0);
        step();

        // Div to unit 1 writes x5; dependent op to unit 0 stalls until after the grant.
        issue(7'b0000010, 1, 0, 5, 0, 0, 3'b000, 3'b000);
        #2 chk("div_issue_stall", 32'(issue_stall), 0);
        step();
        issue(7'b0000001, 1, 0, 6, 5, 0, 3'b001, 3'b000);
        #2 chk("raw_x5_stall_a", 32'(issue_stall), 1);
        chk("outstanding_div", 32'(outstanding), 1);
        step();
        #2 chk("raw_x5_stall_b", 32'(issue_stall), 1);
        step();
        fu_done = 7'b0000010;
        push(7'b0000010, 5, 0, 1);
        #2 chk("raw_x5_stall_grant_cycle", 32'(issue_stall), 1);
        step();
        fu_done = '0;
        #2 chk("raw_x5_released", 32'(issue_stall), 0);
        chk("outstanding_after_div", 32'(outstanding), 0);
        step();
        idle();
        #2 chk("outstanding_add", 32'(outstanding), 1);
        step();
        fu_done = 7'b0000001;
        push(7'b0000001, 6, 0, 1);
        step();
        fu_done = '0;
        #2 chk("outstanding_add_done", 32'(outstanding), 0);

        // Separate int/FP busy files, structural and WAW hazards.
        issue(7'b0000100, 1, 1, 3, 0, 0, 3'b000, 3'b000);
        #2 chk("fp_f3_issue", 32'(issue_stall), 0);
        step();
        issue(7'b0001000, 1, 0, 3, 0, 3, 3'b010, 3'b000);
        #2 chk("raw_int_x3_vs_f3", 32'(issue_stall), 0);
        step();
        issue(7'b0010000, 0, 0, 0, 0, 3, 3'b010, 3'b010);
        #1 chk("raw_fp_f3", 32'(issue_stall), 1);
        src_rs2 = 4;
        #1 chk("raw_fp_f4_free", 32'(issue_stall), 0);
        issue(7'b0000100, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        #1 chk("struct_pending", 32'(issue_stall), 1);
        issue(7'b0100000, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        fu_busy = 7'b0100000;
        #1 chk("struct_fu_busy", 32'(issue_stall), 1);
        fu_busy = '0;
        issue(7'b0100000, 1, 1, 3, 0, 0, 3'b000, 3'b000);
        #1 chk("waw_f3", 32'(issue_stall), 1);
        issue_valid = 1'b0;
        #1 chk("no_valid_no_stall", 32'(issue_stall), 0);
        step();
        idle();
        fu_done = 7'b0001100;
        push(7'b0000100, 3, 1, 1);
        push(7'b0001000, 3, 0, 1);
        #2 chk("hold_unit3", 32'(fu_hold), 32'h08);
        step();
        fu_done = 7'b0001000;
        #2 chk("hold_none", 32'(fu_hold), 0);
        step();
        fu_done = '0;
        #2 chk("outstanding_s2", 32'(outstanding), 0);

        // Units 2 and 4 done together; grant+accept to unit 4 in the same cycle.
        do_reset();
        issue(7'b0000100, 1, 0, 7, 0, 0, 3'b000, 3'b000);
        step();
        issue(7'b0010000, 1, 0, 8, 0, 0, 3'b000, 3'b000);
        step();
        idle();
        fu_done = 7'b0010100;
        push(7'b0000100, 7, 0, 1);
        #2 chk("hold_unit4", 32'(fu_hold), 32'h10);
        chk("outstanding_two", 32'(outstanding), 2);
        step();
        fu_done = 7'b0010000;
        issue(7'b0010000, 1, 0, 9, 0, 0, 3'b000, 3'b000);
        push(7'b0010000, 8, 0, 1);
        #2 chk("grant_accept_same_unit", 32'(issue_stall), 0);
        chk("outstanding_pre_swap", 32'(outstanding), 1);
        step();
        idle();
        fu_done = '0;
        #2 chk("outstanding_swap", 32'(outstanding), 1);
        issue(7'b0000001, 0, 0, 0, 9, 0, 3'b001, 3'b000);
        #1 chk("raw_x9_new_slot", 32'(issue_stall), 1);
        src_rs1 = 8;
        #1 chk("raw_x8_cleared", 32'(issue_stall), 0);
        issue_valid = 1'b0;
        step();
        idle();
        fu_done = 7'b0010000;
        push(7'b0010000, 9, 0, 1);
        step();
        fu_done = '0;
        #2 chk("outstanding_s3", 32'(outstanding), 0);

        // Unit 0 done every cycle against unit 5.
        do_reset();
        issue(7'b0000001, 0, 0, 1, 0, 0, 3'b000, 3'b000);
        step();
        issue(7'b0100000, 0, 0, 2, 0, 0, 3'b000, 3'b000);
        step();
        for (int c = 1; c <= 6; c++) begin
            issue(7'b0000001, 0, 0, 1, 0, 0, 3'b000, 3'b000);
            fu_done = 7'b0100001;
`ifdef FU_ARB_RR_EN
            if (c == 2) push(7'b0100000, 2, 0, 0);
            else        push(7'b0000001, 1, 0, 0);
`else
            push(7'b0000001, 1, 0, 0);
`endif
            #2;
            if (c == 1) chk("starve_hold_c1", 32'(fu_hold), 32'h20);
            if (c == 2) begin
`ifdef FU_ARB_RR_EN
                chk("starve_hold_c2", 32'(fu_hold), 32'h01);
                chk("starve_stall_c2", 32'(issue_stall), 1);
`else
                chk("starve_hold_c2", 32'(fu_hold), 32'h20);
                chk("starve_stall_c2", 32'(issue_stall), 0);
`endif
            end
            step();
        end
        idle();
        fu_done = 7'b0100001;
        push(7'b0000001, 1, 0, 0);
        step();
        fu_done = 7'b0100000;
`ifndef FU_ARB_RR_EN
        push(7'b0100000, 2, 0, 0);
`endif
        #2 chk("starve_final_hold", 32'(fu_hold), 0);
        step();
        fu_done = '0;
        #2 chk("outstanding_s4", 32'(outstanding), 0);

        // Int x0 destination is never busy.
        do_reset();
        issue(7'b1000000, 1, 0, 0, 0, 0, 3'b000, 3'b000);
        #2 chk("x0_issue", 32'(issue_stall), 0);
        step();
        issue(7'b0000010, 0, 0, 0, 0, 0, 3'b001, 3'b000);
        #1 chk("raw_x0", 32'(issue_stall), 0);
        issue(7'b0000010, 1, 0, 0, 0, 0, 3'b000, 3'b000);
        #1 chk("waw_x0", 32'(issue_stall), 0);
        issue_valid = 1'b0;
        chk("outstanding_x0_a", 32'(outstanding), 1);
        step();
        idle();
        #2 chk("outstanding_x0_b", 32'(outstanding), 1);
        fu_done = 7'b1000000;
        push(7'b1000000, 0, 0, 1);
        step();
        fu_done = '0;
        #2 chk("outstanding_x0_done", 32'(outstanding), 0);

        // Reset with three operations in flight.
        issue(7'b0000010, 1, 0, 11, 0, 0, 3'b000, 3'b000);
        step();
        issue(7'b0000100, 1, 0, 12, 0, 0, 3'b000, 3'b000);
        step();
        issue(7'b0001000, 1, 1, 13, 0, 0, 3'b000, 3'b000);
        step();
        idle();
        #2 chk("outstanding_three", 32'(outstanding), 3);
        issue(7'b0000001, 0, 0, 0, 11, 0, 3'b001, 3'b000);
        #1 chk("raw_x11_before_reset", 32'(issue_stall), 1);
        reset_n = 1'b0;
        #1 chk("reset_async_outstanding", 32'(outstanding), 0);
        chk("reset_async_raw_x11", 32'(issue_stall), 0);
        issue(7'b0000001, 0, 0, 0, 13, 0, 3'b001, 3'b001);
        #1 chk("reset_async_raw_f13", 32'(issue_stall), 0);
        idle();
        step();
        step();
        reset_n = 1'b1;
        fu_done = 7'b0001110;
        #2 chk("post_reset_grant", 32'(wb_grant), 0);
        chk("post_reset_hold", 32'(fu_hold), 0);
        chk("post_reset_wb_wr", 32'(wb_wr), 0);
        step();
        fu_done = '0;
        step();
        chk("expect_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
